// File: rtl/beam_sum_pkg.sv
// Shared mic-array constants: beamformer defaults, delay-stage sizing and
// the beam-summer state encoding.
package beam_sum_pkg;

    // Beamformer defaults
    localparam int NUM_MICS_DEF   = 16;
    localparam int DW_DEF         = 19;
    localparam int NORM_SHIFT_DEF = 4;

    // Delay-stage constants (sample-delay lines ahead of the summer)
    localparam int MAX_DELAY      = 32;
    localparam int DELAY_W        = $clog2(MAX_DELAY);

    // Beam-summer sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_NORM  = 2'd2,
        ST_HOLD  = 2'd3
    } beam_state_e;

endpackage

// File: rtl/beam_sum_sat_round_shift.sv
// Round-half-up arithmetic right shift followed by saturation to OW bits.
module sat_round_shift #(
    parameter int IW = 23,
    parameter int OW = 19,
    parameter int SH = 4
) (
    input  logic signed [IW-1:0] acc_i,
    output logic        [OW-1:0] data_o
);

    // One guard bit so the rounding increment can never wrap the accumulator.
    localparam logic signed [IW:0] HALF = (IW+1)'(1) << (SH-1);
    localparam logic signed [IW:0] MAXV = {{(IW-OW+2){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [IW:0] MINV = {{(IW-OW+2){1'b1}}, {(OW-1){1'b0}}};

    logic signed [IW:0] rounded;
    logic signed [IW:0] shifted;

    // Round, shift and clamp into the output range.
    always_comb begin
        rounded = {acc_i[IW-1], acc_i} + HALF;
        shifted = rounded >>> SH;
        if (shifted > MAXV) begin
            data_o = MAXV[OW-1:0];
        end else if (shifted < MINV) begin
            data_o = MINV[OW-1:0];
        end else begin
            data_o = shifted[OW-1:0];
        end
    end

endmodule

// File: rtl/beam_sum.sv
// Delay-and-sum beam summer: serially accumulates the masked channels of one
// captured sample set, normalises with rounding/saturation and holds the
// result on a valid/ready output.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for pcm_valid; capture bus and mask on the strobe
// ST_ACCUM | adding channel cnt_q (0 .. NUM_MICS-1) into the accumulator
// ST_NORM  | rounding/saturating the sum into sum_data
// ST_HOLD  | sum_valid high until sum_ready; accept edge may recapture
module beam_sum
    import beam_sum_pkg::*;
#(
    parameter int NUM_MICS   = NUM_MICS_DEF,
    parameter int DW         = DW_DEF,
    parameter int NORM_SHIFT = NORM_SHIFT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pcm_valid,
    input  logic [NUM_MICS*DW-1:0] pcm_bus,
    input  logic [NUM_MICS-1:0]    chan_mask,
    output logic [DW-1:0]          sum_data,
    output logic                   sum_valid,
    input  logic                   sum_ready,
    output logic                   overrun
);

    localparam int AW = DW + NORM_SHIFT;
    localparam int CW = (NUM_MICS > 1) ? $clog2(NUM_MICS) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_MICS - 1);

    beam_state_e              state_q;
    logic [NUM_MICS*DW-1:0]   pcm_q;
    logic [NUM_MICS-1:0]      mask_q;
    logic signed [AW-1:0]     acc_q;
    logic [CW-1:0]            cnt_q;
    logic [DW-1:0]            sum_data_q;
    logic                     sum_valid_q;
    logic                     overrun_q;

    logic [DW-1:0]            ch_sel;
    logic                     ch_on;
    logic signed [AW-1:0]     addend;
    logic [DW-1:0]            norm_data;

    // Pick the channel addressed by the counter out of the captured set.
    always_comb begin
        ch_sel = '0;
        ch_on  = 1'b0;
        for (int k = 0; k < NUM_MICS; k++) begin
            if (cnt_q == CW'(k)) begin
                ch_sel = pcm_q[k*DW +: DW];
                ch_on  = mask_q[k];
            end
        end
        addend = ch_on ? {{NORM_SHIFT{ch_sel[DW-1]}}, ch_sel} : '0;
    end

    sat_round_shift #(
        .IW (AW),
        .OW (DW),
        .SH (NORM_SHIFT)
    ) u_sat (
        .acc_i  (acc_q),
        .data_o (norm_data)
    );

    // Sequencing FSM with registered outputs; strobes outside IDLE or the
    // accept edge are dropped and flagged as overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pcm_q       <= '0;
            mask_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sum_data_q  <= '0;
            sum_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pcm_valid) begin
                        pcm_q   <= pcm_bus;
                        mask_q  <= chan_mask;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    acc_q <= acc_q + addend;
                    if (cnt_q == LAST_CH) begin
                        state_q <= ST_NORM;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (pcm_valid) overrun_q <= 1'b1;
                end
                ST_NORM: begin
                    sum_data_q  <= norm_data;
                    sum_valid_q <= 1'b1;
                    state_q     <= ST_HOLD;
                    if (pcm_valid) overrun_q <= 1'b1;
                end
                ST_HOLD: begin
                    if (sum_ready) begin
                        sum_valid_q <= 1'b0;
                        if (pcm_valid) begin
                            pcm_q   <= pcm_bus;
                            mask_q  <= chan_mask;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= ST_ACCUM;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (pcm_valid) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sum_data  = sum_data_q;
    assign sum_valid = sum_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/beam_sum.md
BEAM_SUM -- requirements
Module: beam_sum

Interface
REQ-001 SHALL have parameter NUM_MICS, default 16: number of delayed microphone channels summed.
REQ-002 SHALL have parameter DW, default 19: signed PCM sample width, input and output.
REQ-003 SHALL have parameter NORM_SHIFT, default 4: right-shift applied to the channel sum (log2 NUM_MICS).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port pcm_valid  input  1  single-cycle strobe: a new delayed sample set is present on pcm_bus.
REQ-007 SHALL have port pcm_bus  input  NUM_MICS*DW  packed two's-complement samples; channel k occupies bits [k*DW +: DW].
REQ-008 SHALL have port chan_mask  input  NUM_MICS  1 = channel included in sum; sampled with pcm_bus.
REQ-009 SHALL have port sum_data  output  DW  normalised, rounded, saturated beam sample.
REQ-010 SHALL have port sum_valid  output  1  sum_data valid; held until accepted.
REQ-011 SHALL have port sum_ready  input  1  downstream accept; transfer when sum_valid && sum_ready.
REQ-012 SHALL have port overrun  output  1  sticky: a pcm_valid strobe was dropped.

Function
REQ-013 SHALL implement FSM states IDLE, ACCUM, NORM, HOLD.
REQ-014 IDLE: on pcm_valid, SHALL snapshot pcm_bus and chan_mask, clear accumulator and channel counter, go to ACCUM.
REQ-015 ACCUM: each cycle SHALL add sign-extended channel[cnt] (or 0 if masked) to an accumulator of DW+NORM_SHIFT bits, channel 0 first; after channel NUM_MICS-1, go to NORM.
REQ-016 NORM: SHALL compute (acc + 2^(NORM_SHIFT-1)) >>> NORM_SHIFT, saturate to [-2^(DW-1), 2^(DW-1)-1], register into sum_data, assert sum_valid, go to HOLD.
REQ-017 Latency: pcm_valid sampled at edge T0 SHALL yield sum_valid high after edge T0+NUM_MICS+1 (T17 at defaults).
REQ-018 HOLD: sum_data and sum_valid SHALL remain stable until sum_ready; on the accepting edge, sum_valid drops and FSM returns to IDLE.
REQ-019 Accept edge with pcm_valid also high: SHALL start a new capture (IDLE entry skipped, go to ACCUM directly); no strobe lost.
REQ-020 pcm_valid in ACCUM, NORM, or HOLD (other than REQ-019) SHALL be dropped and SHALL set overrun; overrun clears only on reset.
REQ-021 All-masked set SHALL produce sum_data = 0 with normal latency.
REQ-022 Changes to pcm_bus/chan_mask after capture SHALL not affect the in-progress sum.

Reset
REQ-023 rst SHALL force IDLE, sum_data = 0, sum_valid = 0, overrun = 0, accumulator and counter = 0, immediately and asynchronously.
REQ-024 rst mid-ACCUM or HOLD SHALL abandon the sum; no sum_valid until a fresh pcm_valid after rst release.

Structure
REQ-025 State enum, NUM_MICS, DW, NORM_SHIFT defaults SHALL live in the shared mic-array package alongside the delay-stage constants.
REQ-026 Saturating round-and-shift SHALL be a sub-module, sat_round_shift; remainder flat.

Verification
REQ-027 All 16 channels = 1000, mask FFFF, sum_ready=1 -> sum_data = 1000 after 17 edges, sum_valid high one cycle.
REQ-028 All channels = 262143 (max), mask FFFF -> sum_data = 262143 (saturated, no wrap); all = -262144 -> -262144.
REQ-029 Ch0 = 24, others 0, mask 0001 -> sum_data = 2 (24/16 = 1.5 rounds up); ch0 = -24 -> -1.
REQ-030 sum_ready=0 for 10 cycles after sum_valid, second pcm_valid during HOLD -> sum_data stable, overrun = 1, only one output.
REQ-031 Back-to-back: pcm_valid coincident with accept edge -> second result at accept+17 edges, overrun stays 0.
REQ-032 rst asserted at ACCUM cycle 8 -> all outputs 0 immediately; no sum_valid until next pcm_valid + 17 edges.
